// File: rtl/net_tx_capture_pkg.sv
// rtl/net_tx_capture_pkg.sv - shared widths, descriptor type, FSM states and popcount for net_tx_capture
package net_tx_capture_pkg;

  // Descriptor fields are stored at a fixed maximum width; the top narrows them to AW.
  localparam int DESC_PTR_W   = 16;
  localparam int DESC_BYTES_W = 16;
  localparam int MAX_KEEP_W   = 128;

  typedef struct packed {
    logic [DESC_PTR_W-1:0]   start;
    logic [DESC_PTR_W:0]     flits;
    logic [DESC_BYTES_W-1:0] bytes;
    logic                    dest;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM
`ifdef NET_TX_CAPTURE_DROP_EN
    ,
    ST_DROP
`endif
  } state_t;

  function automatic logic [15:0] popcount(input logic [MAX_KEEP_W-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) n = n + 16'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/net_tx_capture_desc_fifo.sv
// rtl/net_tx_capture_desc_fifo.sv - first-word-fall-through FIFO of packet descriptors
module net_tx_capture_desc_fifo
  import net_tx_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  desc_t                    push_desc,
  input  logic                     pop,
  output desc_t                    head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  desc_t           mem [DEPTH];
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   rd_idx;

  // Descriptor storage; the caller never pushes into a full FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_desc;
  end

  // Indices and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero when empty so stale entries never appear on the outputs
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_idx] : '0;

endmodule

// File: rtl/net_tx_capture.sv
// rtl/net_tx_capture.sv - TX stream capture buffer with per-packet descriptors; drop mode via NET_TX_CAPTURE_DROP_EN
module net_tx_capture
  import net_tx_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int BUF_DEPTH  = 256,
  parameter int DESC_DEPTH = 16,
  parameter int AW         = $clog2(BUF_DEPTH)
) (
  input  logic                  net_clk,
  input  logic                  net_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tdest,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  m_desc_valid,
  input  logic                  m_desc_ready,
  output logic [AW-1:0]         m_desc_start,
  output logic [AW:0]           m_desc_flits,
  output logic [15:0]           m_desc_bytes,
  output logic                  m_desc_dest,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  localparam int DCW = $clog2(DESC_DEPTH) + 1;

  state_t                state, state_nxt;
  logic [AW:0]           wr_ptr, pkt_ptr, free_ptr, used, flit_cnt, prior_flits;
  logic                  ready_en, cur_dest, space_ok, beat, wr_en, push, pop;
  logic [DCW-1:0]        desc_count;
  desc_t                 push_desc, head;
  logic                  head_valid;
  logic                  unused_head_bits;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
`ifdef NET_TX_CAPTURE_DROP_EN
  logic                  rollback, drop_inc;
`endif

  // Space check uses registered state only, so tready never depends on tvalid
  assign used     = wr_ptr - free_ptr;
  assign space_ok = (used < (AW+1)'(BUF_DEPTH)) && (desc_count < DCW'(DESC_DEPTH));

`ifdef NET_TX_CAPTURE_DROP_EN
  assign s_axis_tready = ready_en;
`else
  assign s_axis_tready = ready_en && space_ok;
`endif

  assign beat        = s_axis_tvalid && s_axis_tready;
  assign pop         = head_valid && m_desc_ready;
  assign prior_flits = (state == ST_IDLE) ? '0 : flit_cnt;

  // Descriptor for the packet whose last beat is on the bus this cycle
  always_comb begin
    push_desc       = '0;
    push_desc.start = DESC_PTR_W'(pkt_ptr[AW-1:0]);
    push_desc.flits = (DESC_PTR_W+1)'(prior_flits + 1'b1);
    push_desc.bytes = DESC_BYTES_W'(32'(prior_flits) * 32'(KEEP_WIDTH)
                                    + 32'(popcount(MAX_KEEP_W'(s_axis_tkeep))));
    push_desc.dest  = (state == ST_IDLE) ? s_axis_tdest : cur_dest;
  end

  // State register
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next state and per-beat actions
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    push      = 1'b0;
`ifdef NET_TX_CAPTURE_DROP_EN
    rollback  = 1'b0;
    drop_inc  = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
`ifdef NET_TX_CAPTURE_DROP_EN
          if (!space_ok) begin
            rollback  = 1'b1;
            drop_inc  = s_axis_tlast;
            state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else
`endif
          begin
            wr_en     = 1'b1;
            push      = s_axis_tlast;
            state_nxt = s_axis_tlast ? ST_IDLE : ST_ACCUM;
          end
        end
      end
`ifdef NET_TX_CAPTURE_DROP_EN
      ST_DROP: begin
        if (beat && s_axis_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Buffer pointers, packet bookkeeping and the completed-packet counter
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      ready_en  <= 1'b0;
      wr_ptr    <= '0;
      pkt_ptr   <= '0;
      free_ptr  <= '0;
      flit_cnt  <= '0;
      cur_dest  <= 1'b0;
      pkt_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        flit_cnt <= prior_flits + 1'b1;
        if (state == ST_IDLE) cur_dest <= s_axis_tdest;
      end
`ifdef NET_TX_CAPTURE_DROP_EN
      if (rollback) wr_ptr <= pkt_ptr;
`endif
      if (push) begin
        pkt_ptr   <= wr_ptr + 1'b1;
        pkt_count <= pkt_count + 1'b1;
      end
      if (pop) free_ptr <= free_ptr + m_desc_flits;
    end
  end

`ifdef NET_TX_CAPTURE_DROP_EN
  // Count packets discarded because the buffer or descriptor FIFO overflowed
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn)  drop_count <= '0;
    else if (drop_inc) drop_count <= drop_count + 1'b1;
  end
`else
  assign drop_count = '0;

  // A packet longer than the buffer would deadlock: flag it in simulation
  always @(posedge net_clk) begin
    if (net_aresetn)
      assert (!(state == ST_ACCUM && flit_cnt == (AW+1)'(BUF_DEPTH) && s_axis_tvalid));
  end
`endif

  // Flit buffer write port
  always_ff @(posedge net_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  // Flit buffer read port, one-cycle latency, holds when rd_en is low
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) rd_data <= '0;
    else if (rd_en)   rd_data <= mem[rd_addr];
  end

  net_tx_capture_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk        (net_clk),
    .rst_n      (net_aresetn),
    .push       (push),
    .push_desc  (push_desc),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (desc_count)
  );

  assign m_desc_valid     = head_valid;
  assign m_desc_start     = head.start[AW-1:0];
  assign m_desc_flits     = head.flits[AW:0];
  assign m_desc_bytes     = head.bytes;
  assign m_desc_dest      = head.dest;
  assign unused_head_bits = ^{head.start, head.flits};

endmodule
